// File: rtl/wakeup_queue_pkg.sv
// Shared definitions for the wakeup issue queue and its neighbours
// (select-tree wrapper, rename stage).
//   ENTRIES / TAG_W / PAYLOAD_W : default queue geometry
//   SLOT_W / CNT_W              : slot address and occupancy count widths
//   slot_t                      : one queue entry
//   wk_match()                  : wakeup-port tag compare for a single tag
package wakeup_queue_pkg;

    localparam int unsigned ENTRIES   = 32;
    localparam int unsigned TAG_W     = 6;
    localparam int unsigned PAYLOAD_W = 32;
    localparam int unsigned WK_PORTS  = 2;
    localparam int unsigned SLOT_W    = $clog2(ENTRIES);
    localparam int unsigned CNT_W     = $clog2(ENTRIES + 1);

    typedef struct packed {
        logic                 vld;
        logic                 rdy0;
        logic                 rdy1;
        logic [TAG_W-1:0]     tag0;
        logic [TAG_W-1:0]     tag1;
        logic [TAG_W-1:0]     dst;
        logic [PAYLOAD_W-1:0] payload;
    } slot_t;

    // True when any valid wakeup port broadcasts the given tag.
    function automatic logic wk_match(
        input logic [WK_PORTS-1:0]       wk_v,
        input logic [WK_PORTS*TAG_W-1:0] wk_t,
        input logic [TAG_W-1:0]          tag
    );
        logic hit;
        hit = 1'b0;
        for (int unsigned i = 0; i < WK_PORTS; i++) begin
            hit = hit | (wk_v[i] & (wk_t[i*TAG_W +: TAG_W] == tag));
        end
        return hit;
    endfunction

endpackage

// File: rtl/wakeup_queue_free_slot_finder.sv
// Lowest-index free slot priority encoder.
//   vld   : per-slot valid vector (1 = occupied)
//   found : at least one slot is free
//   addr  : index of the lowest free slot (0 when none is free)
module free_slot_finder #(
    parameter int unsigned N  = 32,
    parameter int unsigned AW = $clog2(N)
) (
    input  logic [N-1:0]  vld,
    output logic          found,
    output logic [AW-1:0] addr
);

    always_comb begin
        found = 1'b0;
        addr  = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (!vld[i] && !found) begin
                found = 1'b1;
                addr  = i[AW-1:0];
            end
        end
    end

endmodule

// File: rtl/wakeup_queue.sv
// Issue-queue entry array feeding the select tree.
// Accepts dispatched micro-ops into the lowest free slot, tracks source
// readiness from two wakeup broadcast ports, exposes a per-slot ready
// vector, and issues/frees the slot granted by the select-tree root.
//   clk, rst          : clock, asynchronous active-high reset
//   flush             : synchronous squash of every entry
//   disp_*            : dispatch handshake and micro-op fields
//   wk_valid, wk_tag  : two wakeup ports, port i at wk_tag[i*TAG_W +: TAG_W]
//   entry_ready       : per-slot valid & both sources ready (registered state only)
//   sel_valid/addr    : select-tree root grant
//   iss_*             : registered issue strobe, dst tag and payload
//   count             : occupied slots
//   sel_err           : registered; last grant hit a non-ready slot
module wakeup_queue
    import wakeup_queue_pkg::*;
#(
    parameter int unsigned ENTRIES   = wakeup_queue_pkg::ENTRIES,
    parameter int unsigned TAG_W     = wakeup_queue_pkg::TAG_W,
    parameter int unsigned PAYLOAD_W = wakeup_queue_pkg::PAYLOAD_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 disp_valid,
    output logic                 disp_ready,
    input  logic [TAG_W-1:0]     disp_src0_tag,
    input  logic [TAG_W-1:0]     disp_src1_tag,
    input  logic                 disp_src0_rdy,
    input  logic                 disp_src1_rdy,
    input  logic [TAG_W-1:0]     disp_dst_tag,
    input  logic [PAYLOAD_W-1:0] disp_payload,
    input  logic [1:0]           wk_valid,
    input  logic [2*TAG_W-1:0]   wk_tag,
    output logic [ENTRIES-1:0]   entry_ready,
    input  logic                 sel_valid,
    input  logic [4:0]           sel_addr,
    output logic                 iss_valid,
    output logic [TAG_W-1:0]     iss_dst_tag,
    output logic [PAYLOAD_W-1:0] iss_payload,
    output logic [5:0]           count,
    output logic                 sel_err
);

    localparam int unsigned AW = $clog2(ENTRIES);
    localparam int unsigned CW = $clog2(ENTRIES + 1);

    slot_t                slots_q [ENTRIES];
    slot_t                slots_d [ENTRIES];
    logic [ENTRIES-1:0]   vld_vec;
    logic [ENTRIES-1:0]   hit0;
    logic [ENTRIES-1:0]   hit1;

    logic                 free_found;
    logic [AW-1:0]        free_addr;

    logic                 accept;
    logic                 sel_hit;
    logic                 issue;
    logic                 bad_grant;
    logic                 byp0;
    logic                 byp1;

    logic                 iss_valid_q, iss_valid_d;
    logic [TAG_W-1:0]     iss_dst_q,   iss_dst_d;
    logic [PAYLOAD_W-1:0] iss_pl_q,    iss_pl_d;
    logic                 sel_err_q,   sel_err_d;
    logic [CW-1:0]        count_q,     count_d;

    // Per-slot readiness and wakeup tag compare.
    for (genvar k = 0; k < ENTRIES; k++) begin : g_slot
        assign vld_vec[k]     = slots_q[k].vld;
        assign entry_ready[k] = slots_q[k].vld & slots_q[k].rdy0 & slots_q[k].rdy1;
        assign hit0[k] = (wk_valid[0] & (wk_tag[0 +: TAG_W]     == slots_q[k].tag0))
                       | (wk_valid[1] & (wk_tag[TAG_W +: TAG_W] == slots_q[k].tag0));
        assign hit1[k] = (wk_valid[0] & (wk_tag[0 +: TAG_W]     == slots_q[k].tag1))
                       | (wk_valid[1] & (wk_tag[TAG_W +: TAG_W] == slots_q[k].tag1));
    end

    free_slot_finder #(
        .N  (ENTRIES),
        .AW (AW)
    ) u_free_slot_finder (
        .vld   (vld_vec),
        .found (free_found),
        .addr  (free_addr)
    );

    // Free vector is pre-edge state: a slot issued this cycle is not
    // offered to dispatch until the following cycle, so the accept slot
    // and the issue slot can never coincide.
    assign disp_ready = free_found;
    assign accept     = disp_valid & free_found & ~flush;
    assign sel_hit    = entry_ready[sel_addr];
    assign issue      = sel_valid & sel_hit & ~flush;
    assign bad_grant  = sel_valid & ~sel_hit & ~flush;

    // Same-cycle wakeup bypass for the incoming micro-op.
    assign byp0 = wk_match(wk_valid, wk_tag, disp_src0_tag);
    assign byp1 = wk_match(wk_valid, wk_tag, disp_src1_tag);

    always_comb begin
        for (int unsigned k = 0; k < ENTRIES; k++) begin
            slots_d[k] = slots_q[k];
            if (flush) begin
                slots_d[k] = '0;
            end else if (issue && (sel_addr == k[4:0])) begin
                slots_d[k] = '0;
            end else if (accept && (free_addr == k[AW-1:0])) begin
                slots_d[k].vld     = 1'b1;
                slots_d[k].rdy0    = disp_src0_rdy | byp0;
                slots_d[k].rdy1    = disp_src1_rdy | byp1;
                slots_d[k].tag0    = disp_src0_tag;
                slots_d[k].tag1    = disp_src1_tag;
                slots_d[k].dst     = disp_dst_tag;
                slots_d[k].payload = disp_payload;
            end else if (slots_q[k].vld) begin
                slots_d[k].rdy0 = slots_q[k].rdy0 | hit0[k];
                slots_d[k].rdy1 = slots_q[k].rdy1 | hit1[k];
            end
        end
    end

    always_comb begin
        iss_valid_d = issue;
        iss_dst_d   = issue ? slots_q[sel_addr].dst     : '0;
        iss_pl_d    = issue ? slots_q[sel_addr].payload : '0;
        sel_err_d   = bad_grant;
        if (flush) begin
            count_d = '0;
        end else begin
            count_d = count_q + CW'(accept) - CW'(issue);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned k = 0; k < ENTRIES; k++) begin
                slots_q[k] <= '0;
            end
            iss_valid_q <= 1'b0;
            iss_dst_q   <= '0;
            iss_pl_q    <= '0;
            sel_err_q   <= 1'b0;
            count_q     <= '0;
        end else begin
            for (int unsigned k = 0; k < ENTRIES; k++) begin
                slots_q[k] <= slots_d[k];
            end
            iss_valid_q <= iss_valid_d;
            iss_dst_q   <= iss_dst_d;
            iss_pl_q    <= iss_pl_d;
            sel_err_q   <= sel_err_d;
            count_q     <= count_d;
        end
    end

    assign iss_valid   = iss_valid_q;
    assign iss_dst_tag = iss_dst_q;
    assign iss_payload = iss_pl_q;
    assign sel_err     = sel_err_q;
    assign count       = count_q;

endmodule

// File: tb/tb_wakeup_queue.sv
module tb_wakeup_queue;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        disp_valid;
    logic        disp_ready;
    logic [5:0]  disp_src0_tag;
    logic [5:0]  disp_src1_tag;
    logic        disp_src0_rdy;
    logic        disp_src1_rdy;
    logic [5:0]  disp_dst_tag;
    logic [31:0] disp_payload;
    logic [1:0]  wk_valid;
    logic [11:0] wk_tag;
    logic [31:0] entry_ready;
    logic        sel_valid;
    logic [4:0]  sel_addr;
    logic        iss_valid;
    logic [5:0]  iss_dst_tag;
    logic [31:0] iss_payload;
    logic [5:0]  count;
    logic        sel_err;

    int checks = 0;
    int errors = 0;

    wakeup_queue #(
        .ENTRIES   (32),
        .TAG_W     (6),
        .PAYLOAD_W (32)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .disp_valid    (disp_valid),
        .disp_ready    (disp_ready),
        .disp_src0_tag (disp_src0_tag),
        .disp_src1_tag (disp_src1_tag),
        .disp_src0_rdy (disp_src0_rdy),
        .disp_src1_rdy (disp_src1_rdy),
        .disp_dst_tag  (disp_dst_tag),
        .disp_payload  (disp_payload),
        .wk_valid      (wk_valid),
        .wk_tag        (wk_tag),
        .entry_ready   (entry_ready),
        .sel_valid     (sel_valid),
        .sel_addr      (sel_addr),
        .iss_valid     (iss_valid),
        .iss_dst_tag   (iss_dst_tag),
        .iss_payload   (iss_payload),
        .count         (count),
        .sel_err       (sel_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_disp(input logic [5:0] s0, input logic r0, input logic [5:0] s1,
                            input logic r1, input logic [5:0] dst, input logic [31:0] pl);
        disp_src0_tag = s0;
        disp_src0_rdy = r0;
        disp_src1_tag = s1;
        disp_src1_rdy = r1;
        disp_dst_tag  = dst;
        disp_payload  = pl;
    endtask

    task automatic dispatch(input logic [5:0] s0, input logic r0, input logic [5:0] s1,
                            input logic r1, input logic [5:0] dst, input logic [31:0] pl);
        set_disp(s0, r0, s1, r1, dst, pl);
        disp_valid = 1'b1;
        tick();
        disp_valid = 1'b0;
    endtask

    task automatic grant(input logic [4:0] a);
        sel_valid = 1'b1;
        sel_addr  = a;
        tick();
        sel_valid = 1'b0;
    endtask

    task automatic test_reset;
        checks++; if (disp_ready !== 1'b1) begin errors++; $display("FAIL reset_disp_ready: got %b want 1", disp_ready); end
        checks++; if (entry_ready !== 32'h0) begin errors++; $display("FAIL reset_entry_ready: got %h want 0", entry_ready); end
        checks++; if (count !== 6'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
        checks++; if (iss_valid !== 1'b0) begin errors++; $display("FAIL reset_iss_valid: got %b want 0", iss_valid); end
        checks++; if (sel_err !== 1'b0) begin errors++; $display("FAIL reset_sel_err: got %b want 0", sel_err); end
    endtask

    task automatic test_single_dispatch;
        dispatch(6'h01, 1'b1, 6'h02, 1'b1, 6'h05, 32'hDEADBEEF);
        checks++; if (entry_ready !== 32'h1) begin errors++; $display("FAIL single_ready: got %h want 00000001", entry_ready); end
        checks++; if (count !== 6'd1) begin errors++; $display("FAIL single_count: got %0d want 1", count); end
        grant(5'd0);
        checks++; if (iss_valid !== 1'b1) begin errors++; $display("FAIL single_iss_valid: got %b want 1", iss_valid); end
        checks++; if (iss_dst_tag !== 6'h05) begin errors++; $display("FAIL single_iss_dst: got %h want 05", iss_dst_tag); end
        checks++; if (iss_payload !== 32'hDEADBEEF) begin errors++; $display("FAIL single_iss_payload: got %h want deadbeef", iss_payload); end
        checks++; if (count !== 6'd0) begin errors++; $display("FAIL single_count_after: got %0d want 0", count); end
        checks++; if (entry_ready !== 32'h0) begin errors++; $display("FAIL single_freed: got %h want 0", entry_ready); end
        tick();
        checks++; if (iss_valid !== 1'b0) begin errors++; $display("FAIL single_iss_drop: got %b want 0", iss_valid); end
    endtask

    task automatic test_wakeup;
        dispatch(6'h11, 1'b0, 6'h22, 1'b1, 6'h07, 32'h0000_1111);
        checks++; if (entry_ready !== 32'h0) begin errors++; $display("FAIL wk_not_ready: got %h want 0", entry_ready); end
        // Wrong tag on port 0 must not wake anything.
        wk_valid = 2'b01; wk_tag = {6'h00, 6'h12};
        tick();
        checks++; if (entry_ready !== 32'h0) begin errors++; $display("FAIL wk_wrong_tag: got %h want 0", entry_ready); end
        wk_valid = 2'b01; wk_tag = {6'h00, 6'h11};
        tick();
        wk_valid = 2'b00;
        checks++; if (entry_ready !== 32'h1) begin errors++; $display("FAIL wk_port0: got %h want 00000001", entry_ready); end
        grant(5'd0);
        checks++; if (iss_dst_tag !== 6'h07) begin errors++; $display("FAIL wk_issue_dst: got %h want 07", iss_dst_tag); end

        // Both sources pending; both ports broadcast the same tag (only src0 matches).
        dispatch(6'h11, 1'b0, 6'h22, 1'b0, 6'h08, 32'h0000_2222);
        wk_valid = 2'b11; wk_tag = {6'h11, 6'h11};
        tick();
        checks++; if (entry_ready !== 32'h0) begin errors++; $display("FAIL wk_dual_partial: got %h want 0", entry_ready); end
        wk_valid = 2'b10; wk_tag = {6'h22, 6'h00};
        tick();
        wk_valid = 2'b00;
        checks++; if (entry_ready !== 32'h1) begin errors++; $display("FAIL wk_port1: got %h want 00000001", entry_ready); end
        grant(5'd0);
        checks++; if (iss_payload !== 32'h0000_2222) begin errors++; $display("FAIL wk_issue_payload: got %h want 00002222", iss_payload); end
    endtask

    task automatic test_bypass;
        // Both sources woken in the dispatch cycle, one per port.
        set_disp(6'h11, 1'b0, 6'h22, 1'b0, 6'h09, 32'h0000_3333);
        disp_valid = 1'b1;
        wk_valid = 2'b11; wk_tag = {6'h11, 6'h22};
        tick();
        disp_valid = 1'b0; wk_valid = 2'b00;
        checks++; if (entry_ready !== 32'h1) begin errors++; $display("FAIL bypass_ready: got %h want 00000001", entry_ready); end
        checks++; if (count !== 6'd1) begin errors++; $display("FAIL bypass_count: got %0d want 1", count); end
        grant(5'd0);
        checks++; if (iss_dst_tag !== 6'h09) begin errors++; $display("FAIL bypass_issue_dst: got %h want 09", iss_dst_tag); end
    endtask

    task automatic test_bad_grant;
        dispatch(6'h01, 1'b1, 6'h01, 1'b1, 6'h10, 32'h1000_0000);
        dispatch(6'h01, 1'b1, 6'h01, 1'b1, 6'h11, 32'h1000_0001);
        dispatch(6'h01, 1'b1, 6'h01, 1'b1, 6'h12, 32'h1000_0002);
        dispatch(6'h15, 1'b0, 6'h01, 1'b1, 6'h13, 32'h1000_0003);
        checks++; if (entry_ready !== 32'h7) begin errors++; $display("FAIL bad_setup_ready: got %h want 00000007", entry_ready); end
        checks++; if (count !== 6'd4) begin errors++; $display("FAIL bad_setup_count: got %0d want 4", count); end
        grant(5'd3);
        checks++; if (sel_err !== 1'b1) begin errors++; $display("FAIL bad_sel_err: got %b want 1", sel_err); end
        checks++; if (iss_valid !== 1'b0) begin errors++; $display("FAIL bad_iss_valid: got %b want 0", iss_valid); end
        checks++; if (count !== 6'd4) begin errors++; $display("FAIL bad_count: got %0d want 4", count); end
        checks++; if (entry_ready !== 32'h7) begin errors++; $display("FAIL bad_state: got %h want 00000007", entry_ready); end
        grant(5'd20);
        checks++; if (sel_err !== 1'b1) begin errors++; $display("FAIL bad_empty_slot: got %b want 1", sel_err); end
        tick();
        checks++; if (sel_err !== 1'b0) begin errors++; $display("FAIL bad_one_cycle: got %b want 0", sel_err); end
    endtask

    task automatic test_back_to_back;
        wk_valid = 2'b01; wk_tag = {6'h00, 6'h15};
        tick();
        wk_valid = 2'b00;
        checks++; if (entry_ready !== 32'hF) begin errors++; $display("FAIL b2b_ready: got %h want 0000000f", entry_ready); end
        sel_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sel_addr = i[4:0];
            tick();
            checks++; if (iss_valid !== 1'b1 || iss_dst_tag !== 6'h10 + i[5:0]) begin
                errors++; $display("FAIL b2b_issue_%0d: got valid=%b dst=%h want valid=1 dst=%h", i, iss_valid, iss_dst_tag, 6'h10 + i[5:0]);
            end
        end
        sel_valid = 1'b0;
        tick();
        checks++; if (iss_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle: got %b want 0", iss_valid); end
        checks++; if (count !== 6'd0) begin errors++; $display("FAIL b2b_count: got %0d want 0", count); end
    endtask

    task automatic test_fill_drain;
        logic [31:0] pl;
        disp_valid = 1'b1;
        for (int i = 0; i < 32; i++) begin
            pl = 32'hA000_0000 + i;
            set_disp(6'h01, 1'b1, 6'h01, 1'b1, i[5:0], pl);
            tick();
        end
        checks++; if (count !== 6'd32) begin errors++; $display("FAIL fill_count: got %0d want 32", count); end
        checks++; if (disp_ready !== 1'b0) begin errors++; $display("FAIL fill_disp_ready: got %b want 0", disp_ready); end
        checks++; if (entry_ready !== 32'hFFFF_FFFF) begin errors++; $display("FAIL fill_ready: got %h want ffffffff", entry_ready); end
        set_disp(6'h01, 1'b1, 6'h01, 1'b1, 6'h3F, 32'hFFFF_0000);
        tick();
        disp_valid = 1'b0;
        checks++; if (count !== 6'd32) begin errors++; $display("FAIL fill_33rd: got %0d want 32", count); end
        grant(5'd7);
        checks++; if (iss_dst_tag !== 6'h07 || iss_payload !== 32'hA000_0007) begin
            errors++; $display("FAIL drain_slot7: got dst=%h pl=%h want dst=07 pl=a0000007", iss_dst_tag, iss_payload);
        end
        checks++; if (disp_ready !== 1'b1) begin errors++; $display("FAIL drain_disp_ready: got %b want 1", disp_ready); end
        checks++; if (entry_ready !== 32'hFFFF_FF7F) begin errors++; $display("FAIL drain_ready: got %h want ffffff7f", entry_ready); end
        dispatch(6'h01, 1'b1, 6'h01, 1'b1, 6'h2A, 32'h2A2A_2A2A);
        checks++; if (count !== 6'd32) begin errors++; $display("FAIL refill_count: got %0d want 32", count); end
        // Issue and dispatch together while full: the dispatch is not taken.
        set_disp(6'h01, 1'b1, 6'h01, 1'b1, 6'h3E, 32'h3E3E_3E3E);
        disp_valid = 1'b1; sel_valid = 1'b1; sel_addr = 5'd7;
        #1;
        checks++; if (disp_ready !== 1'b0) begin errors++; $display("FAIL full_same_cycle_ready: got %b want 0", disp_ready); end
        tick();
        disp_valid = 1'b0; sel_valid = 1'b0;
        checks++; if (iss_dst_tag !== 6'h2A) begin errors++; $display("FAIL reuse_slot7: got %h want 2a", iss_dst_tag); end
        checks++; if (count !== 6'd31) begin errors++; $display("FAIL full_issue_count: got %0d want 31", count); end
        tick();
        checks++; if (entry_ready !== 32'hFFFF_FF7F) begin errors++; $display("FAIL dropped_disp: got %h want ffffff7f", entry_ready); end
    endtask

    task automatic test_flush;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++; if (count !== 6'd0 || entry_ready !== 32'h0) begin
            errors++; $display("FAIL flush_full: got count=%0d ready=%h want 0/0", count, entry_ready);
        end
        for (int i = 0; i < 10; i++) dispatch(6'h01, 1'b1, 6'h01, 1'b1, 6'h20, 32'h0);
        checks++; if (count !== 6'd10) begin errors++; $display("FAIL flush_setup: got %0d want 10", count); end
        flush = 1'b1; disp_valid = 1'b1; sel_valid = 1'b1; sel_addr = 5'd0;
        wk_valid = 2'b01; wk_tag = 12'h001;
        tick();
        flush = 1'b0; disp_valid = 1'b0; sel_valid = 1'b0; wk_valid = 2'b00;
        checks++; if (count !== 6'd0) begin errors++; $display("FAIL flush_count: got %0d want 0", count); end
        checks++; if (entry_ready !== 32'h0) begin errors++; $display("FAIL flush_ready: got %h want 0", entry_ready); end
        checks++; if (iss_valid !== 1'b0) begin errors++; $display("FAIL flush_iss_valid: got %b want 0", iss_valid); end
        checks++; if (sel_err !== 1'b0) begin errors++; $display("FAIL flush_sel_err: got %b want 0", sel_err); end
        checks++; if (disp_ready !== 1'b1) begin errors++; $display("FAIL flush_disp_ready: got %b want 1", disp_ready); end
    endtask

    task automatic test_async_reset;
        dispatch(6'h01, 1'b1, 6'h01, 1'b1, 6'h01, 32'h5555_AAAA);
        grant(5'd0);
        checks++; if (iss_valid !== 1'b1) begin errors++; $display("FAIL arst_setup: got %b want 1", iss_valid); end
        dispatch(6'h01, 1'b1, 6'h01, 1'b1, 6'h02, 32'h1234_5678);
        #2;
        rst = 1'b1;
        #1;
        checks++; if (iss_valid !== 1'b0 || iss_dst_tag !== 6'h0 || iss_payload !== 32'h0) begin
            errors++; $display("FAIL arst_iss: got v=%b dst=%h pl=%h want 0", iss_valid, iss_dst_tag, iss_payload);
        end
        checks++; if (count !== 6'd0 || entry_ready !== 32'h0 || sel_err !== 1'b0) begin
            errors++; $display("FAIL arst_state: got count=%0d ready=%h err=%b want 0", count, entry_ready, sel_err);
        end
        tick();
        #2;
        rst = 1'b0;
        tick();
        checks++; if (disp_ready !== 1'b1 || count !== 6'd0 || entry_ready !== 32'h0) begin
            errors++; $display("FAIL arst_release: got dr=%b count=%0d ready=%h want 1/0/0", disp_ready, count, entry_ready);
        end
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; disp_valid = 1'b0;
        set_disp(6'h0, 1'b0, 6'h0, 1'b0, 6'h0, 32'h0);
        wk_valid = 2'b00; wk_tag = '0; sel_valid = 1'b0; sel_addr = '0;
        #12;
        rst = 1'b0;
        tick();
        test_reset();
        test_single_dispatch();
        test_wakeup();
        test_bypass();
        test_bad_grant();
        test_back_to_back();
        test_fill_drain();
        test_flush();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
